// File: rtl/comma_scan_ctrl_pkg.sv
// Shared types and defaults for the bit-serial comma/pattern scanner.
// Holds the state encoding, the default pattern and a helper for the scan window count.
package comma_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } scan_state_e;

    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_INDEX_SIZE = 4;
    localparam int DEF_PAT_LEN    = 3;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b101;

    // Number of windows visited per word, i.e. the number of SCAN cycles.
    function automatic int scan_cycles(input int word_size, input int pat_len);
        return word_size - pat_len + 1;
    endfunction

endpackage

// File: rtl/comma_window_match.sv
// Combinational window compare: selects word_i[ptr_i -: PAT_LEN] and tests it against PATTERN.
// Pointers below PAT_LEN-1 have no complete window and never match.
module comma_window_match
    import comma_scan_ctrl_pkg::*;
#(
    parameter int                 WORD_SIZE  = DEF_WORD_SIZE,
    parameter int                 INDEX_SIZE = DEF_INDEX_SIZE,
    parameter int                 PAT_LEN    = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = DEF_PATTERN
) (
    input  logic [WORD_SIZE-1:0]  word_i,
    input  logic [INDEX_SIZE-1:0] ptr_i,
    output logic                  match_o
);

    logic [WORD_SIZE-1:0] win_hit;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_SIZE; gi++) begin : g_win
            if (gi >= PAT_LEN - 1) begin : g_full
                assign win_hit[gi] = (ptr_i == INDEX_SIZE'(gi)) &&
                                     (word_i[gi -: PAT_LEN] == PATTERN);
            end else begin : g_partial
                assign win_hit[gi] = 1'b0;
            end
        end
    endgenerate

    assign match_o = |win_hit;

endmodule

// File: rtl/comma_scan_ctrl.sv
// Multi-cycle comma scanner: accepts a word, walks one window per clock from the MSB down,
// then reports first-match index, found flag and overlapping match count for one cycle.
module comma_scan_ctrl
    import comma_scan_ctrl_pkg::*;
#(
    parameter int                 WORD_SIZE  = DEF_WORD_SIZE,
    parameter int                 INDEX_SIZE = DEF_INDEX_SIZE,
    parameter int                 PAT_LEN    = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = DEF_PATTERN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [INDEX_SIZE-1:0] index_out,
    output logic [INDEX_SIZE-1:0] match_cnt
);

    localparam logic [INDEX_SIZE-1:0] TOP_PTR  = INDEX_SIZE'(WORD_SIZE - 1);
    localparam logic [INDEX_SIZE-1:0] LAST_PTR = INDEX_SIZE'(PAT_LEN - 1);

    generate
        if (scan_cycles(WORD_SIZE, PAT_LEN) > (2 ** INDEX_SIZE) - 1) begin : g_bad_index_size
            $error("comma_scan_ctrl: INDEX_SIZE too small for WORD_SIZE/PAT_LEN");
        end
        if (PAT_LEN > WORD_SIZE) begin : g_bad_pat_len
            $error("comma_scan_ctrl: PAT_LEN exceeds WORD_SIZE");
        end
    endgenerate

    scan_state_e state_q, state_d;

    logic [WORD_SIZE-1:0]  word_q,  word_d;
    logic [INDEX_SIZE-1:0] ptr_q,   ptr_d;
    logic [INDEX_SIZE-1:0] first_q, first_d;
    logic [INDEX_SIZE-1:0] cnt_q,   cnt_d;
    logic                  hit_q,   hit_d;
    logic                  found_q, found_d;
    logic [INDEX_SIZE-1:0] index_q, index_d;
    logic [INDEX_SIZE-1:0] mcnt_q,  mcnt_d;

    logic accept;
    logic win_match;

    assign accept = word_valid && (state_q == ST_IDLE);

    comma_window_match #(
        .WORD_SIZE  (WORD_SIZE),
        .INDEX_SIZE (INDEX_SIZE),
        .PAT_LEN    (PAT_LEN),
        .PATTERN    (PATTERN)
    ) u_window_match (
        .word_i  (word_q),
        .ptr_i   (ptr_q),
        .match_o (win_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SCAN;
            ST_SCAN:   if (ptr_q == LAST_PTR) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_ready = (state_q == ST_IDLE);
        busy       = (state_q == ST_SCAN) || (state_q == ST_REPORT);
        done       = (state_q == ST_REPORT);
        found      = found_q;
        index_out  = index_q;
        match_cnt  = mcnt_q;
    end

    // The final window's result is folded into the report registers on the same edge
    // that enters REPORT, so they already cover every window while done is high.
    always_comb begin
        word_d  = word_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        found_d = found_q;
        index_d = index_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = word_in;
                    ptr_d   = TOP_PTR;
                    first_d = '0;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                if (win_match) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!hit_q) begin
                        first_d = ptr_q;
                        hit_d   = 1'b1;
                    end
                end
                if (ptr_q == LAST_PTR) begin
                    found_d = hit_d;
                    index_d = first_d;
                    mcnt_d  = cnt_d;
                end else begin
                    ptr_d = ptr_q - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            ptr_q   <= '0;
            first_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            found_q <= 1'b0;
            index_q <= '0;
            mcnt_q  <= '0;
        end else begin
            word_q  <= word_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            found_q <= found_d;
            index_q <= index_d;
            mcnt_q  <= mcnt_d;
        end
    end

endmodule

// File: tb/tb_comma_scan_ctrl.sv
// Self-checking bench for comma_scan_ctrl: directed steps plus random words against a
// loop-based reference scan and an age-since-accept timing model.
module tb_comma_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        done;
    logic        found;
    logic [3:0]  index_out;
    logic [3:0]  match_cnt;

    comma_scan_ctrl #(
        .WORD_SIZE  (16),
        .INDEX_SIZE (4),
        .PAT_LEN    (3),
        .PATTERN    (3'b101)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .index_out  (index_out),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          age         = -1;   // edges since accept; -1 when idle, 14 = report cycle
    logic [15:0] latched     = '0;
    logic        exp_found   = 1'b0;
    int          exp_idx     = 0;
    int          exp_cnt     = 0;
    bit          streaming   = 1'b0;
    int          prev_acc    = -1;
    int          stream_acc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: slide a 3-bit window from the top of the word down to bit 2.
    function automatic void ref_scan(input logic [15:0] w, output logic f,
                                     output int idx, output int cnt);
        f   = 1'b0;
        idx = 0;
        cnt = 0;
        for (int i = 15; i >= 2; i--) begin
            if (((w >> (i - 2)) & 16'h7) == 16'h5) begin
                cnt++;
                if (!f) begin
                    f   = 1'b1;
                    idx = i;
                end
            end
        end
    endfunction

    task automatic tick();
        logic acc;
        logic dut_acc;
        logic f;
        int   idx;
        int   cnt;
        acc     = word_valid && (age < 0) && !rst;
        dut_acc = word_valid && word_ready && !rst;
        if (acc) latched = word_in;
        @(posedge clk);
        cyc++;
        if (streaming && dut_acc) begin
            if (prev_acc >= 0) chk("accept_spacing", cyc - prev_acc, 16);
            prev_acc = cyc;
            stream_acc++;
        end
        if (rst) begin
            age       = -1;
            exp_found = 1'b0;
            exp_idx   = 0;
            exp_cnt   = 0;
        end else if (acc) begin
            age = 0;
        end else if (age >= 0) begin
            age = (age == 14) ? -1 : age + 1;
        end
        if (age == 14) begin
            ref_scan(latched, f, idx, cnt);
            exp_found = f;
            exp_idx   = idx;
            exp_cnt   = cnt;
        end
        @(negedge clk);
        chk("word_ready", word_ready, age < 0);
        chk("busy", busy, age >= 0);
        chk("done", done, age == 14);
        chk("found", found, exp_found);
        chk("index_out", index_out, exp_idx);
        chk("match_cnt", match_cnt, exp_cnt);
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (word_ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("ready_timeout", word_ready, 1'b1);
    endtask

    // Leaves the bench in the done cycle of the submitted word.
    task automatic run_word(input logic [15:0] w);
        wait_ready();
        word_in    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        repeat (14) begin
            word_in = 16'($urandom);
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        word_valid = 1'b1;
        word_in    = 16'h0005;
        repeat (3) tick();
        rst        = 1'b0;
        word_valid = 1'b0;
        chk("rst_ready", word_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_index", index_out, 4'd0);
        tick();
        tick();
        chk("rst_no_accept", busy, 1'b0);

        run_word(16'h0005);
        chk("t2_done", done, 1'b1);
        chk("t2_found", found, 1'b1);
        chk("t2_index", index_out, 4'd2);
        chk("t2_cnt", match_cnt, 4'd1);
        tick();
        chk("t2_done_pulse", done, 1'b0);
        chk("t2_hold", index_out, 4'd2);

        run_word(16'h0AA0);
        chk("t3_found", found, 1'b1);
        chk("t3_index", index_out, 4'd11);
        chk("t3_cnt", match_cnt, 4'd3);
        tick();

        run_word(16'hA00F);
        chk("t4_index", index_out, 4'd15);
        chk("t4_cnt", match_cnt, 4'd1);
        tick();
        run_word(16'h0000);
        chk("t4_zero_found", found, 1'b0);
        chk("t4_zero_index", index_out, 4'd0);
        chk("t4_zero_cnt", match_cnt, 4'd0);
        tick();
        run_word(16'hFFFF);
        chk("t4_ones_found", found, 1'b0);
        chk("t4_ones_index", index_out, 4'd0);
        chk("t4_ones_cnt", match_cnt, 4'd0);
        tick();

        wait_ready();
        streaming  = 1'b1;
        prev_acc   = -1;
        stream_acc = 0;
        word_valid = 1'b1;
        repeat (48) begin
            word_in = 16'($urandom);
            tick();
        end
        word_valid = 1'b0;
        streaming  = 1'b0;
        chk("stream_accepts", stream_acc, 3);
        repeat (4) tick();

        run_word(16'h0AA0);
        tick();
        wait_ready();
        word_in    = 16'h0AA0;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_found", found, 1'b0);
        chk("t6_index", index_out, 4'd0);
        chk("t6_cnt", match_cnt, 4'd0);
        repeat (16) tick();
        run_word(16'h0005);
        chk("t6_index_after", index_out, 4'd2);
        chk("t6_cnt_after", match_cnt, 4'd1);
        tick();

        repeat (24) begin
            run_word(16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
